// File: rtl/pdm_array_decimator.sv
// pdm_array_decimator
// Multichannel PDM microphone capture front-end. Samples MIC_NUMBER PDM lines
// on a selectable edge of the (asynchronous) mic bit clock, counts ones per
// channel over a DECIM-bit window, converts to signed PCM (2*ones - DECIM) and
// streams each frame one enabled channel at a time over valid/ready.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_bclk       mic bit clock level (asynchronous)
//   i_mic_data   PDM data lines (asynchronous)
//   i_enable     capture enable; low holds accumulators and bit counter at 0
//   i_edge_sel   0 = sample on bclk rise, 1 = on bclk fall
//   i_ch_en      per-channel output mask, sampled at window end
//   i_clr_ovr    clears o_overrun (a simultaneous set wins)
//   o_data       signed PCM sample
//   o_chan       channel index of o_data
//   o_valid      sample valid, held until i_ready
//   o_last       last enabled channel of the frame
//   i_ready      downstream accept
//   o_overrun    sticky: window completed while a frame was still streaming
//   o_frame_cnt  number of frames latched (wraps)
module pdm_array_decimator #(
  parameter int unsigned MIC_NUMBER = 16,
  parameter int unsigned DECIM      = 64,
  parameter int unsigned CNT_W      = $clog2(DECIM + 1),
  parameter int unsigned OUT_W      = CNT_W + 1,
  parameter int unsigned FCNT_W     = 16,
  parameter int unsigned CH_W       = (MIC_NUMBER > 1) ? $clog2(MIC_NUMBER) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_bclk,
  input  logic [MIC_NUMBER-1:0]   i_mic_data,
  input  logic                    i_enable,
  input  logic                    i_edge_sel,
  input  logic [MIC_NUMBER-1:0]   i_ch_en,
  input  logic                    i_clr_ovr,
  output logic signed [OUT_W-1:0] o_data,
  output logic [CH_W-1:0]         o_chan,
  output logic                    o_valid,
  output logic                    o_last,
  input  logic                    i_ready,
  output logic                    o_overrun,
  output logic [FCNT_W-1:0]       o_frame_cnt
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DECIM - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t state, state_d;

  logic [1:0]            bclk_sync;
  logic                  bclk_d;
  logic [MIC_NUMBER-1:0] data_meta, data_sync;
  logic                  strobe, sample, win_end;

  logic [CNT_W-1:0]      bit_cnt;
  logic [CNT_W-1:0]      acc      [MIC_NUMBER];
  logic [CNT_W-1:0]      acc_next [MIC_NUMBER];
  logic [CNT_W-1:0]      shadow   [MIC_NUMBER];
  logic [MIC_NUMBER-1:0] mask_q;

  logic                  valid_d, last_d;
  logic signed [OUT_W-1:0] data_d;
  logic [CH_W-1:0]       chan_d, first_idx, next_idx;

  // Lowest set bit of m at or above start (0 if none).
  function automatic logic [CH_W-1:0] first_set(input logic [MIC_NUMBER-1:0] m,
                                                input int start);
    logic [CH_W-1:0] r;
    r = '0;
    for (int i = int'(MIC_NUMBER) - 1; i >= 0; i--) begin
      if (m[i] && (i >= start)) r = CH_W'(i);
    end
    return r;
  endfunction

  // Any set bit of m strictly above idx.
  function automatic logic any_above(input logic [MIC_NUMBER-1:0] m,
                                     input logic [CH_W-1:0] idx);
    logic r;
    r = 1'b0;
    for (int i = 0; i < int'(MIC_NUMBER); i++) begin
      if (m[i] && (i > int'(idx))) r = 1'b1;
    end
    return r;
  endfunction

  // Ones count to signed PCM: 2*ones - DECIM.
  function automatic logic signed [OUT_W-1:0] to_pcm(input logic [CNT_W-1:0] ones);
    return $signed(OUT_W'({ones, 1'b0}) - OUT_W'(DECIM));
  endfunction

  // Synchronisers; data and bclk share the same two-flop latency.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bclk_sync <= '0;
      bclk_d    <= 1'b0;
      data_meta <= '0;
      data_sync <= '0;
    end else begin
      bclk_sync <= {bclk_sync[0], i_bclk};
      bclk_d    <= bclk_sync[1];
      data_meta <= i_mic_data;
      data_sync <= data_meta;
    end
  end

  assign strobe  = i_edge_sel ? (~bclk_sync[1] & bclk_d) : (bclk_sync[1] & ~bclk_d);
  assign sample  = strobe & i_enable;
  assign win_end = sample && (bit_cnt == LAST_BIT);

  // Accumulator plus the bit being sampled now.
  always_comb begin
    for (int c = 0; c < int'(MIC_NUMBER); c++) begin
      acc_next[c] = acc[c] + CNT_W'(data_sync[c]);
    end
  end

  // Accumulation, frame latch, frame counter and overrun flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int c = 0; c < int'(MIC_NUMBER); c++) begin
        acc[c]    <= '0;
        shadow[c] <= '0;
      end
      bit_cnt     <= '0;
      mask_q      <= '0;
      o_frame_cnt <= '0;
      o_overrun   <= 1'b0;
    end else begin
      if (!i_enable || win_end) begin
        for (int c = 0; c < int'(MIC_NUMBER); c++) acc[c] <= '0;
        bit_cnt <= '0;
      end else if (sample) begin
        for (int c = 0; c < int'(MIC_NUMBER); c++) acc[c] <= acc_next[c];
        bit_cnt <= bit_cnt + CNT_W'(1);
      end

      if (win_end && (state == IDLE)) begin
        for (int c = 0; c < int'(MIC_NUMBER); c++) shadow[c] <= acc_next[c];
        mask_q      <= i_ch_en;
        o_frame_cnt <= o_frame_cnt + FCNT_W'(1);
      end

      if (win_end && (state != IDLE)) o_overrun <= 1'b1;
      else if (i_clr_ovr)             o_overrun <= 1'b0;
    end
  end

  assign first_idx = first_set(i_ch_en, 0);
  assign next_idx  = first_set(mask_q, int'(o_chan) + 1);

  // Stream FSM next state and next output register values.
  always_comb begin
    state_d = state;
    valid_d = o_valid;
    data_d  = o_data;
    chan_d  = o_chan;
    last_d  = o_last;
    case (state)
      IDLE: begin
        // First beat comes straight from the just-completed window.
        if (win_end && (|i_ch_en)) begin
          state_d = SEND;
          valid_d = 1'b1;
          chan_d  = first_idx;
          data_d  = to_pcm(acc_next[first_idx]);
          last_d  = ~any_above(i_ch_en, first_idx);
        end
      end
      SEND: begin
        if (o_valid && i_ready) begin
          if (o_last) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            chan_d = next_idx;
            data_d = to_pcm(shadow[next_idx]);
            last_d = ~any_above(mask_q, next_idx);
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_chan  <= '0;
      o_last  <= 1'b0;
    end else begin
      state   <= state_d;
      o_valid <= valid_d;
      o_data  <= data_d;
      o_chan  <= chan_d;
      o_last  <= last_d;
    end
  end

endmodule

// File: tb/tb_pdm_array_decimator.sv
// Directed bench for pdm_array_decimator with MIC_NUMBER=4, DECIM=8.
module tb_pdm_array_decimator;

  localparam int unsigned MICS  = 4;
  localparam int unsigned DEC   = 8;
  localparam int unsigned OUTW  = 5;
  localparam int unsigned FCW   = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   bclk;
  logic [MICS-1:0]        mic;
  logic                   enable;
  logic                   edge_sel;
  logic [MICS-1:0]        ch_en;
  logic                   clr_ovr;
  logic signed [OUTW-1:0] data;
  logic [1:0]             chan;
  logic                   valid;
  logic                   last;
  logic                   ready;
  logic                   overrun;
  logic [FCW-1:0]         frame_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int exp_fc   = 0;

  typedef struct {
    logic [1:0]             ch;
    logic signed [OUTW-1:0] d;
    logic                   l;
    int                     cyc;
  } beat_t;
  beat_t beats[$];

  // Expected PCM of the reference pattern per channel: 8 ones, 0, 4 ones, 6 ones.
  int ref_pcm[MICS] = '{8, -8, 0, 4};

  pdm_array_decimator #(
    .MIC_NUMBER(MICS), .DECIM(DEC), .FCNT_W(FCW)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_bclk(bclk), .i_mic_data(mic),
    .i_enable(enable), .i_edge_sel(edge_sel), .i_ch_en(ch_en),
    .i_clr_ovr(clr_ovr), .o_data(data), .o_chan(chan), .o_valid(valid),
    .o_last(last), .i_ready(ready), .o_overrun(overrun),
    .o_frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every handshake, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      beat_t b;
      b.ch = chan; b.d = data; b.l = last; b.cyc = cyc;
      beats.push_back(b);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference pattern bit i: ch0=1, ch1=0, ch2 alternating, ch3 one for i<6.
  function automatic logic [MICS-1:0] pat(input int i);
    logic [MICS-1:0] r;
    r[0] = 1'b1;
    r[1] = 1'b0;
    r[2] = ((i % 2) == 1);
    r[3] = (i < 6);
    return r;
  endfunction

  // One bclk period: low then high, data stable across both phases.
  task automatic drive_bit(input logic [MICS-1:0] d);
    bclk = 1'b0; mic = d;
    tick(4);
    bclk = 1'b1;
    tick(4);
  endtask

  // Lines high only while bclk is low.
  task automatic drive_bit_low_ones();
    bclk = 1'b0; mic = '1;
    tick(4);
    bclk = 1'b1; mic = '0;
    tick(4);
  endtask

  task automatic run_ref_window();
    for (int i = 0; i < int'(DEC); i++) drive_bit(pat(i));
  endtask

  // Compare recorded beats to the reference frame under mask m, then clear.
  task automatic check_beats(input string tag, input logic [MICS-1:0] m, input bit contiguous);
    int n_exp, hi, k;
    n_exp = 0; hi = 0; k = 0;
    for (int c = 0; c < int'(MICS); c++) if (m[c]) begin n_exp++; hi = c; end
    check({tag, "_nbeats"}, beats.size(), n_exp);
    for (int c = 0; c < int'(MICS); c++) begin
      if (m[c] && k < beats.size()) begin
        check({tag, "_chan"}, beats[k].ch, c);
        check({tag, "_data"}, beats[k].d, ref_pcm[c]);
        check({tag, "_last"}, beats[k].l, (c == hi));
        if (contiguous && k > 0) check({tag, "_nobubble"}, beats[k].cyc, beats[k-1].cyc + 1);
        k++;
      end
    end
    beats.delete();
  endtask

  initial begin
    rst = 1'b1; bclk = 1'b0; mic = '0; enable = 1'b0; edge_sel = 1'b0;
    ch_en = '1; clr_ovr = 1'b0; ready = 1'b1;
    tick(3);
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_last", last, 0);
    check("rst_overrun", overrun, 0);
    check("rst_fcnt", frame_cnt, 0);
    rst = 1'b0;
    tick(2);

    // 1: full mask, ready high
    enable = 1'b1;
    run_ref_window();
    tick(8);
    exp_fc++;
    check_beats("t1", 4'hF, 1'b1);
    check("t1_fcnt", frame_cnt, exp_fc);

    // 2: sparse mask
    ch_en = 4'b1010;
    run_ref_window();
    tick(8);
    exp_fc++;
    check_beats("t2", 4'b1010, 1'b1);
    check("t2_fcnt", frame_cnt, exp_fc);

    // 3: backpressure over two windows -> overrun, first frame preserved
    ch_en = 4'hF; ready = 1'b0;
    run_ref_window();
    exp_fc++;
    check("t3_hold_valid", valid, 1);
    check("t3_hold_chan", chan, 0);
    check("t3_hold_data", data, 8);
    check("t3_ovr_before", overrun, 0);
    for (int i = 0; i < int'(DEC); i++) drive_bit('0);
    check("t3_overrun", overrun, 1);
    check("t3_fcnt", frame_cnt, exp_fc);
    check("t3_still_valid", valid, 1);
    check("t3_still_chan", chan, 0);
    check("t3_still_data", data, 8);
    ready = 1'b1;
    tick(8);
    check_beats("t3", 4'hF, 1'b1);
    check("t3_ovr_sticky", overrun, 1);
    clr_ovr = 1'b1;
    tick(1);
    clr_ovr = 1'b0;
    check("t3_ovr_clr", overrun, 0);

    // 4: edge selection
    edge_sel = 1'b1;
    for (int i = 0; i < int'(DEC); i++) drive_bit_low_ones();
    tick(8);
    exp_fc++;
    check("t4f_nbeats", beats.size(), 4);
    foreach (beats[k]) check("t4f_data", beats[k].d, 8);
    beats.delete();
    edge_sel = 1'b0;
    for (int i = 0; i < int'(DEC); i++) drive_bit_low_ones();
    tick(8);
    exp_fc++;
    check("t4r_nbeats", beats.size(), 4);
    foreach (beats[k]) check("t4r_data", beats[k].d, -8);
    beats.delete();
    check("t4_fcnt", frame_cnt, exp_fc);

    // 5: reset during beat 2
    ready = 1'b0;
    run_ref_window();
    check("t5_beat1_chan", chan, 0);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    check("t5_beat2_valid", valid, 1);
    check("t5_beat2_chan", chan, 1);
    rst = 1'b1;
    #1;
    check("t5_rst_valid", valid, 0);
    check("t5_rst_fcnt", frame_cnt, 0);
    exp_fc = 0;
    bclk = 1'b0; mic = '0;
    tick(2);
    rst = 1'b0;
    beats.delete();
    ready = 1'b1;
    tick(2);
    for (int i = 0; i < int'(DEC) - 1; i++) drive_bit(pat(i));
    tick(8);
    check("t5_early_valid", valid, 0);
    check("t5_early_fcnt", frame_cnt, 0);
    check("t5_early_nbeats", beats.size(), 0);
    drive_bit(pat(DEC - 1));
    tick(8);
    exp_fc++;
    check_beats("t5", 4'hF, 1'b1);
    check("t5_fcnt", frame_cnt, exp_fc);

    // 6: enable low for 3 strobes mid-window
    for (int i = 0; i < 4; i++) drive_bit('0);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) drive_bit('1);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) drive_bit(pat(i));
    tick(8);
    check("t6_mid_fcnt", frame_cnt, exp_fc);
    for (int i = 4; i < int'(DEC); i++) drive_bit(pat(i));
    tick(8);
    exp_fc++;
    check_beats("t6", 4'hF, 1'b1);
    check("t6_fcnt", frame_cnt, exp_fc);
    check("t6_overrun", overrun, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
